// File: rtl/mem_wb_stage.sv
// Purpose: MIPS back end; performs the data-memory access of an EX result and drives the register-file write port.
// Latency: ALU op writes 1 cycle after accept; load writes 1 cycle after mem_ready; stores never write.
// Backpressure: freeze (registered, = state MEM) holds upstream while a memory access is outstanding.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, ALU_Res, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN   EX-stage result
//   freeze                        upstream hold
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready  data-memory handshake
//   WB_Write_Enable, WB_Dest, WB_Data                            register-file write port
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [DATA_W-1:0] Reg2,
  input  logic [REG_W-1:0]  Dest,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              WB_EN,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              WB_Write_Enable,
  output logic [REG_W-1:0]  WB_Dest,
  output logic [DATA_W-1:0] WB_Data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_freeze;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [REG_W-1:0]    r_dest;
  logic                r_is_load;
  logic                r_wb_en;
  logic                r_wb_we;
  logic [REG_W-1:0]    r_wb_dest;
  logic [DATA_W-1:0]   r_wb_data;

  logic                w_accept;
  logic                w_is_mem;

  // A new op can enter whenever no memory access is outstanding, including
  // the WB cycle: the write in flight lives in its own output registers.
  assign w_accept = in_valid && (r_state != S_MEM);
  assign w_is_mem = MEM_R_EN | MEM_W_EN;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_freeze    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dest      <= '0;
      r_is_load   <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
    end else begin
      // Write strobe is a one-cycle pulse unless re-armed below.
      r_wb_we <= 1'b0;
      case (r_state)
        S_MEM: begin
          // Request fields stay frozen until the memory completes.
          if (mem_ready) begin
            r_freeze  <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_load && r_wb_en) begin
              r_state   <= S_WB;
              r_wb_we   <= |r_dest;   // $zero is never written
              r_wb_dest <= r_dest;
              r_wb_data <= mem_rdata;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_dest    <= Dest;
            r_is_load <= MEM_R_EN;   // read wins when both enables are set
            r_wb_en   <= WB_EN;
            if (w_is_mem) begin
              r_state     <= S_MEM;
              r_freeze    <= 1'b1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= MEM_W_EN & ~MEM_R_EN;
              r_mem_addr  <= {ALU_Res[DATA_W-1:2], 2'b00};
              r_mem_wdata <= Reg2;
            end else if (WB_EN) begin
              r_state   <= S_WB;
              r_wb_we   <= |Dest;
              r_wb_dest <= Dest;
              r_wb_data <= ALU_Res;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign freeze          = r_freeze;
  assign mem_req         = r_mem_req;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign WB_Write_Enable = r_wb_we;
  assign WB_Dest         = r_wb_dest;
  assign WB_Data         = r_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose: self-checking bench for mem_wb_stage with a transaction-level reference model.
// Latency: expected write/freeze cycles are derived from accept times and memory latency.
// Backpressure: ops are held on the inputs while the model says the stage is frozen.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] ALU_Res = '0;
  logic [31:0] Reg2 = '0;
  logic [4:0]  Dest = '0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic        WB_EN = 1'b0;
  logic        freeze, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        WB_Write_Enable;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Data;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALU_Res(ALU_Res), .Reg2(Reg2),
    .Dest(Dest), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .WB_Write_Enable(WB_Write_Enable), .WB_Dest(WB_Dest), .WB_Data(WB_Data)
  );

  typedef struct {
    bit        vld;
    bit [31:0] alu;
    bit [31:0] reg2;
    bit [4:0]  dest;
    bit        rd;
    bit        wr;
    bit        wben;
    int        lat;
  } op_t;

  typedef struct {
    int        cyc;
    bit [4:0]  dest;
    bit [31:0] data;
  } wr_t;

  typedef struct {
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        we;
  } mx_t;

  op_t       ops[$];
  wr_t       exp_wr[$];
  mx_t       exp_mem[$];
  bit [31:0] mem_m [bit [31:0]];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  fz_lo = 1;
  int  fz_hi = 0;
  int  lat_cnt = 0;
  int  nfz = 0;
  bit  rand_ready = 1'b0;
  bit  cur_act = 1'b0;
  op_t cur;

  function automatic bit [31:0] mem_rd(bit [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : (a ^ 32'h3C3C_0F0F);
  endfunction

  function automatic op_t mk(bit vld, bit [31:0] alu, bit [31:0] reg2, bit [4:0] dest,
                             bit rd, bit wr, bit wben, int lat);
    op_t o;
    o.vld = vld; o.alu = alu; o.reg2 = reg2; o.dest = dest;
    o.rd = rd; o.wr = wr; o.wben = wben; o.lat = lat;
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model of an accepted op: what memory traffic, freeze window and
  // register write it must produce, expressed in cycles relative to acceptance.
  task automatic accept(op_t o);
    mx_t m;
    wr_t w;
    if (!o.vld) return;
    if (o.rd || o.wr) begin
      m.addr  = {o.alu[31:2], 2'b00};
      m.we    = o.wr && !o.rd;
      m.wdata = o.reg2;
      exp_mem.push_back(m);
      fz_lo   = cyc + 1;
      fz_hi   = cyc + 1 + o.lat;
      lat_cnt = o.lat;
      if (o.rd && o.wben && o.dest != 0) begin
        w.cyc = cyc + 2 + o.lat; w.dest = o.dest; w.data = mem_rd(m.addr);
        exp_wr.push_back(w);
      end
    end else if (o.wben && o.dest != 0) begin
      w.cyc = cyc + 1; w.dest = o.dest; w.data = o.alu;
      exp_wr.push_back(w);
    end
  endtask

  task automatic cycle();
    wr_t w;
    mx_t m;
    bit  fz_exp;
    bit  we_exp;
    @(negedge clk);
    cyc++;
    fz_exp = (cyc >= fz_lo) && (cyc <= fz_hi);
    if (freeze === 1'b1) nfz++;
    chk("freeze", {31'b0, freeze}, {31'b0, fz_exp});
    chk("mem_req", {31'b0, mem_req}, {31'b0, fz_exp});
    we_exp = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
    chk("wb_we", {31'b0, WB_Write_Enable}, {31'b0, we_exp});
    if (we_exp) begin
      w = exp_wr.pop_front();
      if (WB_Write_Enable === 1'b1) begin
        chk("wb_dest", {27'b0, WB_Dest}, {27'b0, w.dest});
        chk("wb_data", WB_Data, w.data);
      end
    end
    // Memory responder
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (mem_req === 1'b1) begin
      if (lat_cnt == 0) begin
        mem_ready = 1'b1;
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", 32'd1, 32'd0);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
          chk("mem_wdata", mem_wdata, m.wdata);
        end
        if (mem_we === 1'b1) mem_m[mem_addr] = mem_wdata;
        mem_rdata = mem_rd(mem_addr);
      end else begin
        lat_cnt--;
      end
    end else if (rand_ready) begin
      mem_ready = 1'($urandom % 2);   // must be ignored outside MEM
    end
    // Upstream: present next op, hold it while the model says frozen.
    if (!cur_act) begin
      if (ops.size() > 0) begin
        cur = ops.pop_front();
        cur_act = 1'b1;
        in_valid = cur.vld; ALU_Res = cur.alu; Reg2 = cur.reg2; Dest = cur.dest;
        MEM_R_EN = cur.rd; MEM_W_EN = cur.wr; WB_EN = cur.wben;
      end else begin
        in_valid = 1'b0;
      end
    end
    if (cur_act && (!cur.vld || !fz_exp)) begin
      accept(cur);
      cur_act = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    run(2);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_dest", {27'b0, WB_Dest}, 32'd0);
    chk("rst_wb_data", WB_Data, 32'd0);
    rst = 1'b0;
    run(2);

    // Back-to-back ALU ops: one write per cycle, no freeze
    ops.push_back(mk(1, 32'h11, 32'h0, 5'd3, 0, 0, 1, 0));
    ops.push_back(mk(1, 32'h22, 32'h0, 5'd4, 0, 0, 1, 0));
    ops.push_back(mk(1, 32'h33, 32'h0, 5'd5, 0, 0, 1, 0));
    nfz = 0;
    run(6);
    chk("alu_stream_freeze_cycles", 32'(nfz), 32'd0);

    // Load with wait states: ready in the third MEM cycle
    mem_m[32'h100] = 32'hDEAD_BEEF;
    nfz = 0;
    ops.push_back(mk(1, 32'h103, 32'h1234, 5'd8, 1, 0, 1, 2));
    run(8);
    chk("load_freeze_cycles", 32'(nfz), 32'd3);

    // Store with zero-wait memory, no write-back
    nfz = 0;
    ops.push_back(mk(1, 32'h40, 32'hCAFE, 5'd7, 0, 1, 0, 0));
    run(5);
    chk("store_freeze_cycles", 32'(nfz), 32'd1);
    chk("store_mem_content", mem_m.exists(32'h40) ? mem_m[32'h40] : 32'h0, 32'hCAFE);

    // $zero destination followed by a normal op
    ops.push_back(mk(1, 32'h55, 32'h0, 5'd0, 0, 0, 1, 0));
    ops.push_back(mk(1, 32'h66, 32'h0, 5'd2, 0, 0, 1, 0));
    run(5);

    // Load followed immediately by an ALU op held under freeze
    ops.push_back(mk(1, 32'h200, 32'h0, 5'd9, 1, 0, 1, 1));
    ops.push_back(mk(1, 32'h77, 32'h0, 5'd10, 0, 0, 1, 0));
    run(8);

    // Both enables set: behaves as a load
    ops.push_back(mk(1, 32'h2A6, 32'hBAD0, 5'd12, 1, 1, 1, 0));
    run(6);

    // Reset during MEM: load is discarded
    ops.push_back(mk(1, 32'h300, 32'h0, 5'd11, 1, 0, 1, 20));
    run(3);
    rst = 1'b1;
    exp_wr.delete();
    exp_mem.delete();
    fz_hi = cyc;
    lat_cnt = 1000;
    run(2);
    rst = 1'b0;
    chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_wdata", mem_wdata, 32'd0);
    chk("rst_mid_wb_dest", {27'b0, WB_Dest}, 32'd0);
    chk("rst_mid_wb_data", WB_Data, 32'd0);
    run(6);

    // Randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int  k;
      bit  rd;
      bit  wr;
      k  = int'($urandom % 8);
      rd = (k == 4) || (k == 5) || (k == 7);
      wr = (k == 6) || (k == 7);
      if ($urandom % 6 == 0) ops.push_back(mk(0, $urandom, $urandom, 5'd1, 0, 0, 1, 0));
      ops.push_back(mk(1, $urandom, $urandom, 5'($urandom_range(0, 31)), rd, wr,
                       ($urandom % 4) != 0, int'($urandom % 4)));
    end
    for (int i = 0; i < 3000 && (ops.size() > 0 || cur_act); i++) cycle();
    chk("ops_drained", 32'(ops.size()), 32'd0);
    run(12);
    chk("writes_pending", 32'(exp_wr.size()), 32'd0);
    chk("mem_pending", 32'(exp_mem.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Back end of the MIPS pipeline: takes an EX-stage result, performs any data-memory access over a req/ready handshake, and drives the write-back port (WB_Write_Enable / WB_Dest / WB_Data) that updates the register file inside the decode stage. It is the producer for that write port. During a memory access it stalls the upstream pipeline through `freeze`.

## Interface
Parameters:
- DATA_W, 32: data/address width.
- REG_W, 5: register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX result valid this cycle.
- ALU_Res  in  DATA_W  ALU result; also the memory byte address.
- Reg2  in  DATA_W  store data.
- Dest  in  REG_W  destination register.
- MEM_R_EN  in  1  load.
- MEM_W_EN  in  1  store.
- WB_EN  in  1  result is written to the register file.
- freeze  out  1  upstream must hold its outputs and `in_valid`.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  word-aligned address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1.
- mem_ready  in  1  access complete this cycle.
- WB_Write_Enable  out  1  register-file write strobe.
- WB_Dest  out  REG_W  write index.
- WB_Data  out  DATA_W  write data.

## Operation
- FSM states: IDLE, MEM, WB. Reset: state=IDLE. All outputs 0 (freeze, mem_req, mem_we, mem_addr, mem_wdata, WB_Write_Enable, WB_Dest, WB_Data).
- Accept condition: in_valid=1 and state is IDLE or WB. On accept, latch ALU_Res, Reg2, Dest, MEM_R_EN, MEM_W_EN, WB_EN.
- Next state after accept:
  - MEM_R_EN or MEM_W_EN → MEM.
  - else WB_EN → WB.
  - else IDLE (bubble; no write).
- No accept in WB → IDLE. No accept in IDLE → stay IDLE.
- MEM state:
  - mem_req=1, mem_addr={ALU_Res[31:2],2'b00}, mem_wdata=Reg2.
  - mem_we=1 for a store, 0 for a load.
  - All three are stable until mem_ready.
  - in_valid is ignored in this state.
- MEM state when mem_ready=1:
  - Load: capture mem_rdata. Go to WB if WB_EN=1, else IDLE.
  - Store: go to IDLE.
- mem_ready outside MEM is ignored.
- MEM_R_EN and MEM_W_EN both set: treated as a load (read wins). mem_we=0.
- WB state:
  - WB_Write_Enable=1 for exactly one cycle.
  - WB_Dest = latched Dest.
  - WB_Data = captured mem_rdata for a load, latched ALU_Res otherwise.
- Dest=0 ($zero): WB_Write_Enable is held 0. The FSM still passes through WB.
- freeze = (state==MEM). It is a registered state decode with no combinational path from in_valid or mem_ready.
- WB_Dest and WB_Data hold their last value outside WB. Only WB_Write_Enable qualifies them.

## Timing
- ALU op accepted at edge N: WB_Write_Enable high during cycle N+1. Back-to-back ALU ops give one write per cycle with no freeze.
- Load accepted at edge N:
  - mem_req and freeze high from cycle N+1.
  - mem_ready high in cycle M: mem_req and freeze drop at M+1, and the WB write is in cycle M+1.
  - A zero-wait memory (mem_ready in N+1) gives the write in N+2.
- Store: same as a load, but the FSM returns to IDLE at M+1 with no write.
- An instruction presented while freeze=1 is accepted on the first edge after freeze falls. Upstream keeps it stable until then.
- A new op accepted in the WB cycle does not disturb the write in progress.
- rst during MEM: state→IDLE on the next edge. mem_req drops and the pending load's write-back is discarded.
- rst during WB: WB_Write_Enable=0 from the next cycle.

## Test plan
- Reset: assert rst 2 cycles mid-load (state MEM) → next cycle all outputs 0, no WB_Write_Enable ever for that load.
- ALU stream: ops Dest=3/ALU_Res=0x11, Dest=4/0x22, Dest=5/0x33 on consecutive cycles → WB writes (3,0x11),(4,0x22),(5,0x33) in consecutive cycles, freeze never high.
- Load with wait states: ALU_Res=0x103, Dest=8. mem_ready after 3 cycles with mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, freeze high exactly 3 cycles, then write (8,0xDEADBEEF).
- Store: ALU_Res=0x40, Reg2=0xCAFE, WB_EN=0. mem_ready in the first MEM cycle → mem_we=1, mem_wdata=0xCAFE, freeze 1 cycle, no WB_Write_Enable.
- Dest=0: ALU op with WB_EN=1, Dest=0 → WB_Write_Enable stays 0. A following op to Dest=2 writes normally one cycle later.
- Load followed immediately by ALU op (held under freeze): ALU op written the cycle after the load's write.
